// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the board input controller: CPU modes, switch field
// positions and push-button indices.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_PROG  = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_DEBUG = 2'b11
  } mode_e;

  localparam int unsigned SW_W  = 18;
  localparam int unsigned KEY_W = 4;

  // Slide-switch field positions
  localparam int unsigned SW_MODE_HI  = 17;
  localparam int unsigned SW_MODE_LO  = 16;
  localparam int unsigned SW_SPEED_HI = 15;
  localparam int unsigned SW_SPEED_LO = 13;
  localparam int unsigned SW_LOOP     = 12;
  localparam int unsigned SW_PROG_HI  = 11;
  localparam int unsigned SW_PROG_LO  = 10;
  localparam int unsigned SW_RUN      = 9;

  // Push-button indices
  localparam int unsigned KEY_STEP  = 0;
  localparam int unsigned KEY_RSTPC = 1;
  localparam int unsigned KEY_SAVE  = 2;
  localparam int unsigned KEY_BACK  = 3;

endpackage

// File: rtl/cpu_input_ctrl_debounce.sv
// Single push-button front end: synchroniser, stable-count debouncer and a
// one-cycle pulse on each debounced released->pressed transition.
module key_debounce #(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   deb_n_q, deb_n_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;

  // Synchroniser chain; resets to released (high)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; flip the debounced level on the last one
  always_comb begin
    deb_n_d = deb_n_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (synced != deb_n_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_n_d = synced;
        press_d = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deb_n_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      deb_n_q <= deb_n_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/cpu_input_ctrl.sv
// Board input controller: synchronises switches, debounces keys and decodes
// the CPU mode into registered level and pulse controls, including the
// program-entry address counter and instruction latch.
module cpu_input_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned INSTR_W     = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [17:0]        sw_raw,
  input  logic [3:0]         key_n_raw,
  output logic [1:0]         mode,
  output logic               mode_change,
  output logic [2:0]         clkspeed,
  output logic [ADDR_W-1:0]  addressdisplay,
  output logic               enableloop,
  output logic [1:0]         selectprog,
  output logic               runprog,
  output logic               resetcpu,
  output logic               resetpc,
  output logic               manualclk,
  output logic               backclk,
  output logic               saveinstr,
  output logic [ADDR_W-1:0]  prog_addr,
  output logic [INSTR_W-1:0] proginstruction
);

  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q;
  logic [SW_W-1:0]                  sw_s;
  logic [KEY_W-1:0]                 press;
  logic [KEY_W-1:0]                 act;
  logic                             chg;
  logic [ADDR_W-1:0]                addr_base;

  mode_e              mode_q, mode_d;
  logic               mode_change_q, mode_change_d;
  logic [2:0]         clkspeed_q, clkspeed_d;
  logic [ADDR_W-1:0]  addrdisp_q, addrdisp_d;
  logic               enableloop_q, enableloop_d;
  logic [1:0]         selectprog_q, selectprog_d;
  logic               runprog_q, runprog_d;
  logic               resetcpu_q, resetcpu_d;
  logic               resetpc_q, resetpc_d;
  logic               manualclk_q, manualclk_d;
  logic               backclk_q, backclk_d;
  logic               saveinstr_q, saveinstr_d;
  logic [ADDR_W-1:0]  prog_addr_q, prog_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               save_pend_q, save_pend_d;

  // Switch synchroniser chain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sw_sync_q <= '0;
    else         sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_deb (
      .clk      (clk),
      .resetn   (resetn),
      .key_n_raw(key_n_raw[k]),
      .press    (press[k])
    );
  end

  // Mode decode, key actions and program-entry address update
  always_comb begin
    mode_d        = mode_e'(sw_s[SW_MODE_HI:SW_MODE_LO]);
    chg           = (mode_d != mode_q);
    mode_change_d = chg;
    act           = chg ? '0 : press;

    clkspeed_d    = '0;
    addrdisp_d    = '0;
    enableloop_d  = 1'b0;
    selectprog_d  = '0;
    runprog_d     = 1'b0;
    resetcpu_d    = 1'b0;
    resetpc_d     = 1'b0;
    manualclk_d   = 1'b0;
    backclk_d     = 1'b0;
    saveinstr_d   = 1'b0;
    instr_d       = instr_q;
    save_pend_d   = 1'b0;

    // A save's deferred increment lands first, so a key action in the
    // following cycle is applied on top of it.
    addr_base     = prog_addr_q + ADDR_W'(save_pend_q);
    prog_addr_d   = addr_base;

    case (mode_d)
      MODE_PROG: begin
        if (act[KEY_RSTPC]) begin
          prog_addr_d = '0;
          resetpc_d   = 1'b1;
        end else if (act[KEY_SAVE]) begin
          instr_d     = sw_s[INSTR_W-1:0];
          saveinstr_d = 1'b1;
          save_pend_d = 1'b1;
        end else if (act[KEY_BACK]) begin
          prog_addr_d = addr_base - ADDR_W'(1);
          backclk_d   = 1'b1;
        end else if (act[KEY_STEP]) begin
          prog_addr_d = addr_base + ADDR_W'(1);
          manualclk_d = 1'b1;
        end
        addrdisp_d = prog_addr_d;
      end
      MODE_RUN, MODE_DEBUG: begin
        clkspeed_d   = (mode_d == MODE_RUN) ? sw_s[SW_SPEED_HI:SW_SPEED_LO] : 3'd0;
        enableloop_d = sw_s[SW_LOOP];
        selectprog_d = sw_s[SW_PROG_HI:SW_PROG_LO];
        runprog_d    = sw_s[SW_RUN];
        addrdisp_d   = sw_s[ADDR_W-1:0];
        resetcpu_d   = act[KEY_SAVE];
        resetpc_d    = act[KEY_RSTPC];
        manualclk_d  = (mode_d == MODE_DEBUG) && act[KEY_STEP];
      end
      default: ;
    endcase
  end

  // Output and program-entry state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q        <= MODE_IDLE;
      mode_change_q <= 1'b0;
      clkspeed_q    <= '0;
      addrdisp_q    <= '0;
      enableloop_q  <= 1'b0;
      selectprog_q  <= '0;
      runprog_q     <= 1'b0;
      resetcpu_q    <= 1'b0;
      resetpc_q     <= 1'b0;
      manualclk_q   <= 1'b0;
      backclk_q     <= 1'b0;
      saveinstr_q   <= 1'b0;
      prog_addr_q   <= '0;
      instr_q       <= '0;
      save_pend_q   <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      clkspeed_q    <= clkspeed_d;
      addrdisp_q    <= addrdisp_d;
      enableloop_q  <= enableloop_d;
      selectprog_q  <= selectprog_d;
      runprog_q     <= runprog_d;
      resetcpu_q    <= resetcpu_d;
      resetpc_q     <= resetpc_d;
      manualclk_q   <= manualclk_d;
      backclk_q     <= backclk_d;
      saveinstr_q   <= saveinstr_d;
      prog_addr_q   <= prog_addr_d;
      instr_q       <= instr_d;
      save_pend_q   <= save_pend_d;
    end
  end

  assign mode            = mode_q;
  assign mode_change     = mode_change_q;
  assign clkspeed        = clkspeed_q;
  assign addressdisplay  = addrdisp_q;
  assign enableloop      = enableloop_q;
  assign selectprog      = selectprog_q;
  assign runprog         = runprog_q;
  assign resetcpu        = resetcpu_q;
  assign resetpc         = resetpc_q;
  assign manualclk       = manualclk_q;
  assign backclk         = backclk_q;
  assign saveinstr       = saveinstr_q;
  assign prog_addr       = prog_addr_q;
  assign proginstruction = instr_q;

endmodule

// File: tb/tb_cpu_input_ctrl.sv
// Self-checking bench for cpu_input_ctrl with short debounce settings.
module tb_cpu_input_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned AW   = 6;
  localparam int unsigned IW   = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [17:0]   sw_raw;
  logic [3:0]    key_n_raw;
  logic [1:0]    mode;
  logic          mode_change;
  logic [2:0]    clkspeed;
  logic [AW-1:0] addressdisplay;
  logic          enableloop;
  logic [1:0]    selectprog;
  logic          runprog;
  logic          resetcpu, resetpc, manualclk, backclk, saveinstr;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] proginstruction;

  cpu_input_ctrl #(
    .DEB_CYCLES (DEB),
    .SYNC_STAGES(SYNC),
    .ADDR_W     (AW),
    .INSTR_W    (IW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sw_raw         (sw_raw),
    .key_n_raw      (key_n_raw),
    .mode           (mode),
    .mode_change    (mode_change),
    .clkspeed       (clkspeed),
    .addressdisplay (addressdisplay),
    .enableloop     (enableloop),
    .selectprog     (selectprog),
    .runprog        (runprog),
    .resetcpu       (resetcpu),
    .resetpc        (resetpc),
    .manualclk      (manualclk),
    .backclk        (backclk),
    .saveinstr      (saveinstr),
    .prog_addr      (prog_addr),
    .proginstruction(proginstruction)
  );

  always #5 clk = ~clk;

  // pul = {resetcpu, resetpc, manualclk, backclk, saveinstr}
  typedef struct packed {
    logic [1:0]  mode;
    logic        mc;
    logic [2:0]  spd;
    logic [5:0]  ad;
    logic        loop;
    logic [1:0]  sel;
    logic        run;
    logic [4:0]  pul;
    logic [5:0]  pa;
    logic [15:0] ins;
  } obs_t;

  typedef struct {
    int unsigned due;
    obs_t        exp;
    int          tag;
  } sb_t;

  typedef struct {
    logic [17:0] sw;
    obs_t        e1;
    obs_t        e2;
  } vec_t;

  obs_t        obs;
  sb_t         sb[$];
  vec_t        vt[7];
  int unsigned cyc;
  int          n_vec;
  int          n_err;
  int          cnt_p[5];

  assign obs = {mode, mode_change, clkspeed, addressdisplay, enableloop, selectprog,
                runprog, {resetcpu, resetpc, manualclk, backclk, saveinstr},
                prog_addr, proginstruction};

  function automatic obs_t mk(input logic [1:0] m, input logic mc, input logic [2:0] spd,
                              input logic [5:0] ad, input logic lp, input logic [1:0] sel,
                              input logic run, input logic [4:0] pl, input logic [5:0] pa,
                              input logic [15:0] ins);
    mk = {m, mc, spd, ad, lp, sel, run, pl, pa, ins};
  endfunction

  task automatic compare(input string name, input obs_t a, input obs_t e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, a, e);
    end
  endtask

  task automatic push(input int unsigned dly, input obs_t e, input int tag);
    sb.push_back('{cyc + dly, e, tag});
  endtask

  // One clock: count pulses and retire due scoreboard entries at the negedge
  task automatic step();
    sb_t t;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 5; i++) if (obs.pul[i]) cnt_p[i]++;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      t = sb.pop_front();
      compare($sformatf("sb%0d", t.tag), obs, t.exp);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 5; i++) cnt_p[i] = 0;
  endtask

  // Clean 10-cycle press of key k with the pulse cycle expectation at +7
  task automatic press_key(input int k, input obs_t e7, input int tag);
    key_n_raw[k] = 1'b0;
    push(7, e7, tag);
    steps(10);
    key_n_raw[k] = 1'b1;
    steps(10);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    clr_cnt();

    vt[0] = '{18'h00000, mk(0,0,0,0,0,0,0,0,0,0),       mk(0,0,0,0,0,0,0,0,0,0)};
    vt[1] = '{18'h20000, mk(2,1,0,0,0,0,0,0,0,0),       mk(2,0,0,0,0,0,0,0,0,0)};
    vt[2] = '{18'h2A200, mk(2,0,5,0,0,0,1,0,0,0),       mk(2,0,5,0,0,0,1,0,0,0)};
    vt[3] = '{18'h2782A, mk(2,0,3,6'h2A,1,2,0,0,0,0),   mk(2,0,3,6'h2A,1,2,0,0,0,0)};
    vt[4] = '{18'h3782A, mk(3,1,0,6'h2A,1,2,0,0,0,0),   mk(3,0,0,6'h2A,1,2,0,0,0,0)};
    vt[5] = '{18'h0782A, mk(0,1,0,0,0,0,0,0,0,0),       mk(0,0,0,0,0,0,0,0,0,0)};
    vt[6] = '{18'h1782A, mk(1,1,0,0,0,0,0,0,0,0),       mk(1,0,0,0,0,0,0,0,0,0)};

    resetn    = 1'b0;
    sw_raw    = '0;
    key_n_raw = 4'hF;
    steps(3);
    compare("reset", obs, '0);
    resetn = 1'b1;
    steps(2);

    // Switch-level table: outputs appear SYNC+1 cycles after the edge
    for (int i = 0; i < 7; i++) begin
      sw_raw = vt[i].sw;
      push(3, vt[i].e1, i);
      push(4, vt[i].e2, 100 + i);
      steps(5);
    end

    // RUN: key2 held 10 cycles gives one resetcpu pulse 7 cycles later
    sw_raw = 18'h2A200;
    steps(6);
    clr_cnt();
    key_n_raw[2] = 1'b0;
    push(6, mk(2,0,5,0,0,0,1,5'b00000,0,0), 10);
    push(7, mk(2,0,5,0,0,0,1,5'b10000,0,0), 11);
    push(8, mk(2,0,5,0,0,0,1,5'b00000,0,0), 12);
    steps(10);
    key_n_raw[2] = 1'b1;
    steps(10);
    chk_int("resetcpu_count", cnt_p[4], 1);
    chk_int("other_pulses_run", cnt_p[3] + cnt_p[2] + cnt_p[1] + cnt_p[0], 0);

    // DEBUG: 3-cycle bounces never debounce, then a clean press does
    sw_raw = 18'h30200;
    steps(6);
    clr_cnt();
    for (int r = 0; r < 5; r++) begin
      key_n_raw[0] = 1'b0;
      steps(3);
      key_n_raw[0] = 1'b1;
      steps(3);
    end
    steps(8);
    chk_int("bounce_manualclk", cnt_p[2], 0);
    key_n_raw[0] = 1'b0;
    push(7, mk(3,0,0,0,0,0,1,5'b00100,0,0), 20);
    push(8, mk(3,0,0,0,0,0,1,5'b00000,0,0), 21);
    steps(10);
    key_n_raw[0] = 1'b1;
    steps(10);
    chk_int("clean_manualclk", cnt_p[2], 1);

    // PROG: save, address reset, back and step with wrap-around
    sw_raw = 18'h1A5C3;
    steps(6);
    key_n_raw[2] = 1'b0;
    push(7, mk(1,0,0,0,0,0,0,5'b00001,0,16'hA5C3), 30);
    push(8, mk(1,0,0,1,0,0,0,5'b00000,1,16'hA5C3), 31);
    steps(10);
    key_n_raw[2] = 1'b1;
    steps(10);
    press_key(1, mk(1,0,0,0,0,0,0,5'b01000,0,16'hA5C3), 32);
    press_key(3, mk(1,0,0,6'd63,0,0,0,5'b00010,6'd63,16'hA5C3), 33);
    press_key(0, mk(1,0,0,0,0,0,0,5'b00100,0,16'hA5C3), 34);
    press_key(0, mk(1,0,0,1,0,0,0,5'b00100,1,16'hA5C3), 35);

    // Simultaneous key1 + key0: reset wins, step dropped
    clr_cnt();
    key_n_raw = 4'b1100;
    push(7, mk(1,0,0,0,0,0,0,5'b01000,0,16'hA5C3), 36);
    steps(10);
    key_n_raw = 4'hF;
    steps(10);
    chk_int("simul_manualclk", cnt_p[2], 0);
    chk_int("simul_resetpc", cnt_p[3], 1);

    // Reset during debounce discards the press and clears program state
    clr_cnt();
    key_n_raw[0] = 1'b0;
    steps(4);
    resetn = 1'b0;
    steps(2);
    key_n_raw[0] = 1'b1;
    compare("reset_mid_debounce", obs, '0);
    resetn = 1'b1;
    steps(15);
    chk_int("post_reset_manualclk", cnt_p[2], 0);
    compare("post_reset_state", obs, mk(1,0,0,0,0,0,0,5'b00000,0,0));

    while (sb.size() != 0) begin
      sb_t t;
      t = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL sb%0d never compared, want=%h", t.tag, t.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_input_ctrl.md
# cpu_input_ctrl

Registered, parametrised successor to the board input decoder. It synchronises the raw DE2 switches and keys, debounces the keys, and turns key presses into single-cycle pulses. It decodes the four CPU modes into control outputs for the clock generator, program memory and display. Unlike the combinational decoder, program mode is functional: it has an address counter and a one-cycle instruction write strobe, so programs can be entered from the switches.

## Interface
Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles required before a debounced key changes state (≥1).
- SYNC_STAGES, 2: synchroniser depth for switches and keys (≥2).
- ADDR_W, 6: program/display address width (1..9).
- INSTR_W, 16: instruction width (1..16).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- sw_raw  in  18  raw slide switches (asynchronous).
- key_n_raw  in  4  raw push-buttons, active-low (asynchronous).
- mode  out  2  registered current mode.
- mode_change  out  1  one-cycle pulse when mode changes.
- clkspeed  out  3  clock-divider select.
- addressdisplay  out  ADDR_W  address shown on the display.
- enableloop  out  1  program loop enable.
- selectprog  out  2  program bank select.
- runprog  out  1  run enable.
- resetcpu, resetpc, manualclk, backclk, saveinstr  out  1 each  one-cycle pulses.
- prog_addr  out  ADDR_W  program-mode write address.
- proginstruction  out  INSTR_W  instruction latched at save.

## Operation
- **Synchronisers.**
  - sw_raw and key_n_raw each pass through a SYNC_STAGES flop chain.
  - At reset, switch flops clear to 0 and key flops set to 1 (released).
- **Debounce (per key).**
  - State: a debounced level `deb` and a counter.
  - The counter increments while the synced key differs from `deb`, and clears whenever they agree.
  - On the DEB_CYCLES-th consecutive differing cycle, `deb` flips and the counter clears.
  - A `press` pulse is raised for one cycle on each debounced released→pressed transition. Releases produce no pulse.
- **Mode register.**
  - Encodings: IDLE=00, PROG=01, RUN=10, DEBUG=11.
  - `mode` loads synced sw[17:16] every cycle.
  - When the loaded value differs from the current one, `mode_change` pulses for one cycle.
  - During that cycle all pulse outputs are forced to 0, and presses that arrive in it are discarded.
- **IDLE.** All outputs are 0 except prog_addr and proginstruction, which hold their values.
- **PROG.** Key actions, in priority order: key1 > key2 > key3 > key0.
  - key1 press: prog_addr ← 0, resetpc pulses.
  - key2 press: proginstruction ← synced sw[INSTR_W-1:0] and saveinstr pulses in the same cycle. prog_addr increments on the following cycle.
  - key3 press: prog_addr decrements (0 wraps to 2^ADDR_W−1), backclk pulses.
  - key0 press: prog_addr increments (max wraps to 0), manualclk pulses.
  - Lower-priority presses in the same cycle are dropped.
  - addressdisplay shows prog_addr. clkspeed=0.
- **RUN.**
  - Level outputs registered from synced switches: clkspeed=sw[15:13], enableloop=sw[12], selectprog=sw[11:10], runprog=sw[9], addressdisplay=sw[ADDR_W-1:0].
  - key2 press → resetcpu pulse. key1 press → resetpc pulse.
  - manualclk, backclk and saveinstr stay 0.
- **DEBUG.** Same as RUN, except clkspeed=0 and key0 press → manualclk pulse.
- prog_addr and proginstruction persist across mode changes and are cleared only by reset.

## Timing
- **Reset values.** Every output is 0. Debounced keys are released and counters are 0.
- **Switch latency.** A switch edge reaches its level output SYNC_STAGES+1 cycles later.
- **Key latency.**
  - A clean key assertion produces its pulse SYNC_STAGES+DEB_CYCLES+1 cycles later.
  - Every pulse is exactly 1 cycle wide. One physical press gives exactly one pulse.
- **Address update.** prog_addr updates in the same cycle as the manualclk/backclk/resetpc pulse, and one cycle after saveinstr. A save and any key action arriving in the following cycle are both applied.
- **Reset mid-debounce.** Asserting resetn during a debounce discards the press; no pulse is emitted after release of reset unless the key is held for a fresh DEB_CYCLES.
- **Bounce.** A glitch shorter than DEB_CYCLES never changes `deb`.

## Structure
- Package cpu_ctrl_pkg holds:
  - the mode encodings (MODE_IDLE, MODE_PROG, MODE_RUN, MODE_DEBUG);
  - switch field positions (SW_MODE_HI/LO, SW_SPEED_HI/LO, SW_LOOP, SW_PROG_HI/LO, SW_RUN);
  - key indices (KEY_STEP=0, KEY_RSTPC=1, KEY_SAVE=2, KEY_BACK=3).
- Sub-module key_debounce (synchroniser, debounce counter, press pulse), instantiated 4× with a generate loop.

## Test plan
Bench setting: DEB_CYCLES=4, SYNC_STAGES=2, ADDR_W=6.

1. Reset, then sw=0 → all outputs 0 and mode=00. Set sw[17:16]=10 → mode=10 and mode_change pulses once, 3 cycles later.
2. RUN mode, sw[15:13]=101 and sw[9]=1 → clkspeed=5 and runprog=1 after 3 cycles. Press key2 for 10 cycles → exactly one resetcpu pulse, 7 cycles after assertion.
3. Key0 bounces with 3-cycle pulses for 30 cycles in DEBUG mode → no manualclk pulse. Then a 10-cycle clean press → exactly one pulse.
4. PROG mode, sw[15:0]=16'hA5C3, press key2 → saveinstr=1 with proginstruction=A5C3 and prog_addr=0. prog_addr=1 on the next cycle.
5. PROG mode at prog_addr=0, press key3 → prog_addr=63. Then key0 → prog_addr=0 (wrap-around).
6. Key1 and key0 become debounced-pressed in the same cycle in PROG mode → prog_addr=0 and resetpc pulses with no manualclk. Pulling resetn low mid-debounce → no pulse.
